datapath_bus: RTL and testbench
===============================

Name: datapath_bus

Overview:
Parametrised next-generation CPU datapath with an external handshaked memory bus in place of a single-cycle internal RAM. It holds the register file, the X/Y/Z/PSW/IR registers and the cycle counter. It drives operands to an external ALU and addresses to the memory bus. The control unit supplies a microinstruction each cycle. This block stalls the control unit while a bus transfer is outstanding and flags odd-address and timeout bus errors.

Parameters:
WIDTH, 16, data/address width; even, at least 16.
NREGS, 8, register file entries; a power of two; entry NREGS-1 is PC.
PSW_W, 8, processor status width.
CYW, 3, cycle counter width.
RESET_PC, 0, PC value after reset.
TIMEOUT, 15, maximum bus wait cycles before a timeout error; at least 1.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
ctl_reg_src  in  log2(NREGS)  source register select
ctl_reg_dst  in  log2(NREGS)  destination register select; also the write address
ctl_reg_we  in  1  register file write
ctl_reg_from_mem  in  1  register write data: 1 selects memory data, 0 selects alu_d
ctl_alu_input  in  2  bit0: alu_a takes X, else src; bit1: alu_b takes Y, else dst
ctl_mem_addr  in  3  address select: 0 src, 1 src+X, 2 dst, 3 dst+Y, 4 X, 5 Y, 6-7 Z
ctl_mem_rd  in  1  memory read request
ctl_mem_we  in  1  memory write request
ctl_mem_byte  in  1  byte access
ctl_x_we, ctl_y_we, ctl_z_we, ctl_psw_we, ctl_ir_we  in  1 each  register loads
ctl_cnext  in  CYW  next cycle count
alu_a, alu_b  out  WIDTH  ALU operands
alu_d  in  WIDTH  ALU result
alu_psr  in  PSW_W  ALU status result
psw  out  PSW_W  status register
ir  out  WIDTH  instruction register
cycle  out  CYW  cycle counter
stall  out  1  control must hold all ctl_* inputs stable while this is 1
bus_err  out  1  sticky bus error
bus_req, bus_we  out  1  bus request and write qualifier
bus_be  out  WIDTH/8  byte enables
bus_addr, bus_wdata  out  WIDTH  bus address and write data
bus_ack  in  1  transfer complete
bus_rdata  in  WIDTH  read data, valid while bus_ack=1

Behaviour:
- Reset (asynchronous):
  - all registers clear to 0, except PC = RESET_PC.
  - cycle=0, psw=0, ir=0, bus_err=0, FSM goes to IDLE.
  - bus_req falls immediately, including mid-transfer.
- Address arithmetic is modulo 2^WIDTH.
- mem_addr is the combinational mux selected by ctl_mem_addr.
- Z loads mem_addr on ctl_z_we, with or without an access.
- Memory data (mdata):
  - word read: bus_rdata.
  - byte read: the byte selected by address bit 0, sign-extended to WIDTH.
- Byte write: bus_wdata = alu_d[7:0] replicated into every lane; bus_be is one-hot on the addressed lane.
- Word access: bus_be = all ones.
- FSM states: IDLE, BUSY, ERR.
- IDLE, no access requested (ctl_mem_rd=ctl_mem_we=0):
  - all enabled writes commit at the clock edge.
  - cycle loads ctl_cnext.
  - stall=0.
- IDLE, access requested, word access with an odd address:
  - bus_req stays 0, stall=1.
  - commits are suppressed.
  - next state ERR.
- IDLE, access requested, otherwise:
  - bus_req=1 combinationally.
  - bus_ack the same cycle: zero-wait commit, stall=0.
  - no bus_ack: stall=1, commits suppressed; address, wdata, be and we are latched; wait counter cleared; next state BUSY.
- BUSY:
  - bus signals are driven from the latched values.
  - stall=1.
  - on bus_ack: commit using the current ctl_* inputs, stall=0, return to IDLE.
  - otherwise the wait counter increments; at TIMEOUT waits without ack, go to ERR.
- ERR:
  - bus_req=0, bus_err=1, stall=1.
  - no commits occur until reset.
- ctl_mem_rd and ctl_mem_we both set counts as a write.
- The read commit cycle can load X, Y, IR and the register file from mdata simultaneously.
- The register file has 2 asynchronous read ports and 1 synchronous write port.
- Same-cycle read/write of one register returns the old value.

Test Plan:
- Reset with RESET_PC=0o1000: PC=0o1000 and cycle=0. Word read at src=PC with zero-wait ack and rdata=0o012700, ctl_ir_we=1: ir=0o012700 after one edge, stall never rises.
- Byte read at address 0o1001 with rdata=0o100200 and 2 wait states: stall high for 2 cycles, X=0xFF80 sign-extended, cycle frozen for 2 cycles and then loads ctl_cnext.
- Byte write at address 0o2001 with alu_d=0x1234: bus_wdata=0x3434 and bus_be=2'b10. Word write at 0o2000: bus_be=2'b11.
- Word read at odd address 0o1003: bus_req never asserts, bus_err=1, stall stuck high. Asserting reset clears both.
- With no ack for 15 cycles: ERR entered and bus_err=1. Reset asserted mid-BUSY: bus_req drops in the same cycle, before the next clk edge.
- With WIDTH=32 and NREGS=16: dst=0xFFFFFFF0, Y=0x20 gives bus_addr=0x10 (wrap-around), and register 15 resets to RESET_PC.

Source files
------------

// File: rtl/datapath_bus_if.sv
// Memory bus between the datapath (master) and external memory (slave).
// Single outstanding transfer; rdata is valid only while ack is high.
interface datapath_bus_if #(
    parameter int WIDTH = 16
);
    logic               req;
    logic               we;
    logic [WIDTH/8-1:0] be;
    logic [WIDTH-1:0]   addr;
    logic [WIDTH-1:0]   wdata;
    logic               ack;
    logic [WIDTH-1:0]   rdata;

    modport master (output req, we, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/datapath_bus.sv
// CPU datapath: register file, X/Y/Z/PSW/IR, cycle counter and a handshaked
// memory bus port. Stalls the control unit while a transfer is outstanding.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready; a request is issued combinationally from ctl_* inputs
// S_BUSY | waiting for ack; bus driven from latched address/data
// S_ERR  | odd word address or timeout; frozen until reset
module datapath_bus #(
    parameter int               WIDTH    = 16,
    parameter int               NREGS    = 8,
    parameter int               PSW_W    = 8,
    parameter int               CYW      = 3,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] ctl_reg_src,
    input  logic [$clog2(NREGS)-1:0] ctl_reg_dst,
    input  logic                     ctl_reg_we,
    input  logic                     ctl_reg_from_mem,
    input  logic [1:0]               ctl_alu_input,
    input  logic [2:0]               ctl_mem_addr,
    input  logic                     ctl_mem_rd,
    input  logic                     ctl_mem_we,
    input  logic                     ctl_mem_byte,
    input  logic                     ctl_x_we,
    input  logic                     ctl_y_we,
    input  logic                     ctl_z_we,
    input  logic                     ctl_psw_we,
    input  logic                     ctl_ir_we,
    input  logic [CYW-1:0]           ctl_cnext,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_d,
    input  logic [PSW_W-1:0]         alu_psr,
    output logic [PSW_W-1:0]         psw,
    output logic [WIDTH-1:0]         ir,
    output logic [CYW-1:0]           cycle,
    output logic                     stall,
    output logic                     bus_err,
    datapath_bus_if.master           bus
);
    localparam int BEW       = WIDTH / 8;
    localparam int LW        = (BEW > 1) ? $clog2(BEW) : 1;
    localparam int WCW       = $clog2(TIMEOUT + 1);
    // The request cycle in IDLE is the first wait, so BUSY sees TIMEOUT-1 more.
    localparam int LAST_WAIT = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_ERR = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rf [NREGS];
    logic [WIDTH-1:0]   x_q, y_q, z_q, ir_q;
    logic [PSW_W-1:0]   psw_q;
    logic [CYW-1:0]     cycle_q;
    logic [WIDTH-1:0]   addr_q, wdata_q;
    logic [BEW-1:0]     be_q;
    logic               we_q;
    logic [WCW-1:0]     wcnt_q;

    logic [WIDTH-1:0]   src_val, dst_val, mem_addr, cur_addr;
    logic [WIDTH-1:0]   req_wdata, mdata, wr_data;
    logic [BEW-1:0]     req_be;
    logic [LW-1:0]      lane;
    logic [7:0]         rd_byte;
    logic               access, word_odd, busy;
    logic               req, commit, latch;

    assign src_val  = rf[ctl_reg_src];
    assign dst_val  = rf[ctl_reg_dst];
    assign alu_a    = ctl_alu_input[0] ? x_q : src_val;
    assign alu_b    = ctl_alu_input[1] ? y_q : dst_val;
    assign access   = ctl_mem_rd | ctl_mem_we;
    assign word_odd = ~ctl_mem_byte & mem_addr[0];
    assign busy     = (state_q == S_BUSY);

    // Memory address select; sums wrap modulo 2^WIDTH.
    always_comb begin
        case (ctl_mem_addr)
            3'd0:    mem_addr = src_val;
            3'd1:    mem_addr = src_val + x_q;
            3'd2:    mem_addr = dst_val;
            3'd3:    mem_addr = dst_val + y_q;
            3'd4:    mem_addr = x_q;
            3'd5:    mem_addr = y_q;
            default: mem_addr = z_q;
        endcase
    end

    assign req_be    = ctl_mem_byte ? (BEW'(1) << mem_addr[LW-1:0]) : '1;
    assign req_wdata = ctl_mem_byte ? {BEW{alu_d[7:0]}} : alu_d;

    assign cur_addr  = busy ? addr_q : mem_addr;
    assign lane      = cur_addr[LW-1:0];
    assign rd_byte   = bus.rdata[{lane, 3'b000} +: 8];
    assign mdata     = ctl_mem_byte ? {{(WIDTH-8){rd_byte[7]}}, rd_byte} : bus.rdata;
    assign wr_data   = ctl_reg_from_mem ? mdata : alu_d;

    // reset gates req directly so it drops before the next edge
    assign bus.req   = req & ~reset;
    assign bus.addr  = cur_addr;
    assign bus.wdata = busy ? wdata_q : req_wdata;
    assign bus.be    = busy ? be_q : req_be;
    assign bus.we    = busy ? we_q : ctl_mem_we;

    assign psw     = psw_q;
    assign ir      = ir_q;
    assign cycle   = cycle_q;
    assign bus_err = (state_q == S_ERR);

    // Next state, request, stall and commit decode.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        commit  = 1'b0;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!access) begin
                    commit = 1'b1;
                end else if (word_odd) begin
                    stall   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    req = 1'b1;
                    if (bus.ack) begin
                        commit = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        latch   = 1'b1;
                        state_d = (TIMEOUT == 1) ? S_ERR : S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                req = 1'b1;
                if (bus.ack) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (wcnt_q == WCW'(LAST_WAIT)) state_d = S_ERR;
                end
            end
            S_ERR:   stall = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, wait counter and latched bus request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                wcnt_q  <= '0;
                addr_q  <= mem_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                we_q    <= ctl_mem_we;
            end else if (busy && !bus.ack) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
        end
    end

    // Architectural registers update only on a commit cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= (i == NREGS - 1) ? RESET_PC : '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            ir_q    <= '0;
            psw_q   <= '0;
            cycle_q <= '0;
        end else if (commit) begin
            if (ctl_reg_we) rf[ctl_reg_dst] <= wr_data;
            if (ctl_x_we)   x_q   <= wr_data;
            if (ctl_y_we)   y_q   <= wr_data;
            if (ctl_z_we)   z_q   <= mem_addr;
            if (ctl_ir_we)  ir_q  <= mdata;
            if (ctl_psw_we) psw_q <= alu_psr;
            cycle_q <= ctl_cnext;
        end
    end
endmodule

// File: tb/tb_datapath_bus.sv
// Directed bench for datapath_bus: a 16-bit instance for the main behaviour
// and a 32-bit instance for wide address wrap and reset PC.
module tb_datapath_bus;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 16-bit instance
    logic [2:0]  src, dst, msel, cnext;
    logic        reg_we, from_mem, rd, we, byt, x_we, y_we, z_we, psw_we, ir_we;
    logic [1:0]  asel;
    logic [15:0] alu_d, alu_a, alu_b, ir;
    logic [7:0]  alu_psr, psw;
    logic [2:0]  cycle;
    logic        stall, bus_err;

    datapath_bus_if #(.WIDTH(16)) bus16 ();

    datapath_bus #(.WIDTH(16), .NREGS(8), .PSW_W(8), .CYW(3),
                   .RESET_PC(16'o1000), .TIMEOUT(15)) dut16 (
        .clk(clk), .reset(reset),
        .ctl_reg_src(src), .ctl_reg_dst(dst), .ctl_reg_we(reg_we),
        .ctl_reg_from_mem(from_mem), .ctl_alu_input(asel), .ctl_mem_addr(msel),
        .ctl_mem_rd(rd), .ctl_mem_we(we), .ctl_mem_byte(byt),
        .ctl_x_we(x_we), .ctl_y_we(y_we), .ctl_z_we(z_we),
        .ctl_psw_we(psw_we), .ctl_ir_we(ir_we), .ctl_cnext(cnext),
        .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_psr(alu_psr),
        .psw(psw), .ir(ir), .cycle(cycle), .stall(stall), .bus_err(bus_err),
        .bus(bus16.master)
    );

    // 32-bit instance
    logic [3:0]  w_src, w_dst;
    logic [2:0]  w_msel, w_cnext, w_cycle;
    logic        w_reg_we, w_from_mem, w_rd, w_we, w_byt, w_x_we, w_y_we, w_z_we, w_psw_we, w_ir_we;
    logic [1:0]  w_asel;
    logic [31:0] w_alu_d, w_alu_a, w_alu_b, w_ir;
    logic [7:0]  w_alu_psr, w_psw;
    logic        w_stall, w_bus_err;

    datapath_bus_if #(.WIDTH(32)) bus32 ();

    datapath_bus #(.WIDTH(32), .NREGS(16), .PSW_W(8), .CYW(3),
                   .RESET_PC(32'h0000_4000), .TIMEOUT(15)) dut32 (
        .clk(clk), .reset(reset),
        .ctl_reg_src(w_src), .ctl_reg_dst(w_dst), .ctl_reg_we(w_reg_we),
        .ctl_reg_from_mem(w_from_mem), .ctl_alu_input(w_asel), .ctl_mem_addr(w_msel),
        .ctl_mem_rd(w_rd), .ctl_mem_we(w_we), .ctl_mem_byte(w_byt),
        .ctl_x_we(w_x_we), .ctl_y_we(w_y_we), .ctl_z_we(w_z_we),
        .ctl_psw_we(w_psw_we), .ctl_ir_we(w_ir_we), .ctl_cnext(w_cnext),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_d(w_alu_d), .alu_psr(w_alu_psr),
        .psw(w_psw), .ir(w_ir), .cycle(w_cycle), .stall(w_stall), .bus_err(w_bus_err),
        .bus(bus32.master)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  src, dst, msel;
        logic [1:0]  asel;
        logic        rd, we, byt;
        logic [15:0] alu_d;
        logic        e_req, e_we;
        logic [15:0] e_addr;
        logic [1:0]  e_be;
        logic [15:0] e_wdata, e_a, e_b;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctl();
        src = 0; dst = 0; msel = 0; cnext = 0; asel = 0;
        reg_we = 0; from_mem = 0; rd = 0; we = 0; byt = 0;
        x_we = 0; y_we = 0; z_we = 0; psw_we = 0; ir_we = 0;
        alu_d = 0; alu_psr = 0;
        bus16.ack = 0; bus16.rdata = 0;
    endtask

    task automatic idle32();
        w_src = 0; w_dst = 0; w_msel = 0; w_cnext = 0; w_asel = 0;
        w_reg_we = 0; w_from_mem = 0; w_rd = 0; w_we = 0; w_byt = 0;
        w_x_we = 0; w_y_we = 0; w_z_we = 0; w_psw_we = 0; w_ir_we = 0;
        w_alu_d = 0; w_alu_psr = 0;
        bus32.ack = 0; bus32.rdata = 0;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [15:0] val);
        idle_ctl();
        reg_we = 1; dst = idx; alu_d = val;
        tick();
        idle_ctl();
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        reset = 0;
        tick();
    endtask

    initial begin
        //        src dst msel asel rd we byt alu_d    req we  addr     be     wdata    a        b
        tbl[0] = '{1, 2, 0, 0, 0, 0, 0, 16'h1234, 0, 0, 16'h0401, 2'b11, 16'h1234, 16'h0401, 16'h0010};
        tbl[1] = '{1, 2, 0, 3, 0, 1, 1, 16'h1234, 1, 1, 16'h0401, 2'b10, 16'h3434, 16'h0002, 16'h0100};
        tbl[2] = '{4, 2, 0, 1, 0, 1, 0, 16'h1234, 1, 1, 16'h0400, 2'b11, 16'h1234, 16'h0002, 16'h0010};
        tbl[3] = '{1, 2, 1, 2, 1, 0, 1, 16'h00A5, 1, 0, 16'h0403, 2'b10, 16'hA5A5, 16'h0401, 16'h0100};
        tbl[4] = '{1, 2, 2, 0, 1, 0, 0, 16'hBEEF, 1, 0, 16'h0010, 2'b11, 16'hBEEF, 16'h0401, 16'h0010};
        tbl[5] = '{1, 2, 3, 0, 0, 1, 1, 16'h7F01, 1, 1, 16'h0110, 2'b01, 16'h0101, 16'h0401, 16'h0010};
        tbl[6] = '{1, 2, 4, 0, 1, 0, 0, 16'h0000, 1, 0, 16'h0002, 2'b11, 16'h0000, 16'h0401, 16'h0010};
        tbl[7] = '{1, 2, 5, 0, 1, 0, 1, 16'h00FF, 1, 0, 16'h0100, 2'b01, 16'hFFFF, 16'h0401, 16'h0010};
        tbl[8] = '{1, 2, 6, 0, 1, 0, 1, 16'h0000, 1, 0, 16'h0401, 2'b10, 16'h0000, 16'h0401, 16'h0010};
        tbl[9] = '{1, 2, 7, 0, 1, 1, 1, 16'h5501, 1, 1, 16'h0401, 2'b10, 16'h0101, 16'h0401, 16'h0010};

        reset = 1;
        idle_ctl();
        idle32();
        #12 reset = 0;

        // reset state
        @(negedge clk);
        src = 7;
        w_src = 15;
        #1;
        chk("reset_pc", alu_a, 16'o1000);
        chk("reset_cycle", cycle, 0);
        chk("reset_psw", psw, 0);
        chk("reset_ir", ir, 0);
        chk("reset_bus_err", bus_err, 0);
        chk("reset_stall", stall, 0);
        chk("reset_pc32", w_alu_a, 32'h0000_4000);
        tick();

        // zero-wait word read into IR
        idle_ctl();
        src = 7; msel = 0; rd = 1; ir_we = 1; psw_we = 1; alu_psr = 8'h5A; cnext = 3;
        bus16.ack = 1; bus16.rdata = 16'o012700;
        @(negedge clk);
        chk("zw_stall", stall, 0);
        chk("zw_req", bus16.req, 1);
        chk("zw_addr", bus16.addr, 16'o1000);
        tick();
        chk("zw_ir", ir, 16'o012700);
        chk("zw_psw", psw, 8'h5A);
        chk("zw_cycle", cycle, 3);

        // register setup
        wr_reg(1, 16'h0401);
        wr_reg(2, 16'h0010);
        wr_reg(3, 16'o1001);
        wr_reg(4, 16'o2000);
        wr_reg(5, 16'o1003);
        x_we = 1; alu_d = 16'h0002; tick(); idle_ctl();
        y_we = 1; alu_d = 16'h0100; tick(); idle_ctl();
        z_we = 1; src = 1; msel = 0; tick(); idle_ctl();

        // single-cycle vectors
        for (int i = 0; i < 10; i++) begin
            idle_ctl();
            src = tbl[i].src; dst = tbl[i].dst; msel = tbl[i].msel; asel = tbl[i].asel;
            rd = tbl[i].rd; we = tbl[i].we; byt = tbl[i].byt; alu_d = tbl[i].alu_d;
            bus16.ack = 1;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), bus16.req, tbl[i].e_req);
            chk($sformatf("v%0d_we", i), bus16.we, tbl[i].e_we);
            chk($sformatf("v%0d_addr", i), bus16.addr, tbl[i].e_addr);
            chk($sformatf("v%0d_be", i), bus16.be, tbl[i].e_be);
            chk($sformatf("v%0d_wdata", i), bus16.wdata, tbl[i].e_wdata);
            chk($sformatf("v%0d_alu_a", i), alu_a, tbl[i].e_a);
            chk($sformatf("v%0d_alu_b", i), alu_b, tbl[i].e_b);
            chk($sformatf("v%0d_stall", i), stall, 0);
            tick();
        end

        // byte read with two wait states into X
        idle_ctl();
        src = 3; msel = 0; rd = 1; byt = 1; from_mem = 1; x_we = 1; cnext = 5;
        bus16.rdata = 16'o100200;
        @(negedge clk);
        chk("br_stall_w1", stall, 1);
        chk("br_req_w1", bus16.req, 1);
        tick();
        chk("br_cycle_w1", cycle, 0);
        @(negedge clk);
        chk("br_stall_w2", stall, 1);
        chk("br_addr_w2", bus16.addr, 16'o1001);
        tick();
        chk("br_cycle_w2", cycle, 0);
        bus16.ack = 1;
        @(negedge clk);
        chk("br_stall_ack", stall, 0);
        tick();
        idle_ctl();
        asel = 1;
        #1;
        chk("br_x", alu_a, 16'hFF80);
        chk("br_cycle", cycle, 5);
        tick();

        // odd word read
        idle_ctl();
        src = 5; msel = 0; rd = 1; ir_we = 1;
        bus16.ack = 1; bus16.rdata = 16'hAAAA;
        @(negedge clk);
        chk("odd_req", bus16.req, 0);
        chk("odd_stall", stall, 1);
        tick();
        @(negedge clk);
        chk("odd_err", bus_err, 1);
        chk("odd_req_err", bus16.req, 0);
        tick();
        idle_ctl();
        #1;
        chk("odd_stall_stuck", stall, 1);
        chk("odd_ir_kept", ir, 16'o012700);
        reset = 1;
        #2;
        chk("odd_rst_err", bus_err, 0);
        chk("odd_rst_stall", stall, 0);
        reset = 0;
        tick();

        // timeout after 15 cycles without ack
        idle_ctl();
        src = 7; msel = 0; rd = 1;
        for (int i = 0; i < 14; i++) tick();
        @(negedge clk);
        chk("to_err_14", bus_err, 0);
        chk("to_req_14", bus16.req, 1);
        chk("to_stall_14", stall, 1);
        tick();
        chk("to_err_15", bus_err, 1);
        chk("to_req_15", bus16.req, 0);
        idle_ctl();
        do_reset();

        // reset mid-BUSY drops req before the next edge
        idle_ctl();
        src = 7; msel = 0; rd = 1;
        tick();
        @(negedge clk);
        chk("mb_req", bus16.req, 1);
        reset = 1;
        #1;
        chk("mb_req_rst", bus16.req, 0);
        idle_ctl();
        #1 reset = 0;
        tick();

        // 32-bit address wrap
        idle32();
        w_reg_we = 1; w_dst = 2; w_alu_d = 32'hFFFF_FFF0;
        tick();
        idle32();
        w_y_we = 1; w_alu_d = 32'h0000_0020;
        tick();
        idle32();
        w_dst = 2; w_msel = 3;
        #1;
        chk("w32_addr_wrap", bus32.addr, 32'h0000_0010);
        chk("w32_stall", w_stall, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
